// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA line-fetch pixel source: display-size
// defaults, RGB565/RGB888 pixel structs, the fetch FSM state type and the
// RGB565 -> RGB888 expansion helper.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_DISP_DEFAULT = 800;
    localparam int unsigned V_DISP_DEFAULT = 600;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {
        StIdle,
        StFetch
    } fetch_state_e;

    // Bit replication maps full-scale 565 codes onto full-scale 888 (0x1F -> 0xFF).
    function automatic rgb888_t rgb565_to_888(input rgb565_t p);
        rgb888_t q;
        q.r = {p.r, p.r[4:2]};
        q.g = {p.g, p.g[5:4]};
        q.b = {p.b, p.b[4:2]};
        return q;
    endfunction

endpackage

// File: rtl/vga_line_ram.sv
// ----------------------------------------------------------------------------
// vga_line_ram
// One bank of the display line buffer: DEPTH x 16-bit RGB565 words, one
// write port and one registered read port.
// Ports:
//   clk      - pixel clock
//   i_we     - write enable; i_waddr/i_wdata - write address/data
//   i_re     - read enable;  i_raddr         - read address
//   o_rdata  - read data, valid the cycle after i_re
// ----------------------------------------------------------------------------
module vga_line_ram #(
    parameter int unsigned DEPTH = 800,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rdata;

    // Storage only; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_line_fetch.sv
// ----------------------------------------------------------------------------
// vga_line_fetch
// Prefetches one display line of RGB565 pixels from frame memory into a
// double-buffered line buffer and returns RGB888 per requested pixel with
// one cycle of latency.
// Ports:
//   clk, rst_n           - pixel clock, async active-low reset
//   i_frame_start        - restart fetching at line 0
//   i_line_start         - end of displayed line; swap banks, fetch next line
//   i_de, i_x            - pixel request from the timing stage
//   o_rgb_r/g/b          - pixel colour, one cycle after i_de/i_x
//   o_mem_req/o_mem_addr - frame-memory read request and word address
//   i_mem_ack/i_mem_rdata- one-cycle ack with RGB565 read data
//   o_underrun_cnt       - aborted-fetch count (VGA_LINE_FETCH_UNDERRUN_EN only)
// Optional feature macro: VGA_LINE_FETCH_UNDERRUN_EN adds the underrun
// counter and shows unfetched pixels in magenta instead of black.
// ----------------------------------------------------------------------------
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter int unsigned H_DISP = H_DISP_DEFAULT,
    parameter int unsigned V_DISP = V_DISP_DEFAULT,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned X_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_start,
    input  logic              i_line_start,
    input  logic              i_de,
    input  logic [X_W-1:0]    i_x,
    output logic [7:0]        o_rgb_r,
    output logic [7:0]        o_rgb_g,
    output logic [7:0]        o_rgb_b,
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    output logic [7:0]        o_underrun_cnt,
`endif
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [15:0]       i_mem_rdata
);

    localparam int unsigned RAM_AW = $clog2(H_DISP);
    localparam int unsigned FILL_W = $clog2(H_DISP + 1);
    localparam int unsigned LF_W   = $clog2(V_DISP + 1);

    fetch_state_e               r_state, w_state_nxt;
    logic                       r_disp_bank, w_disp_bank_nxt;
    logic [1:0][FILL_W-1:0]     r_fill, w_fill_nxt;
    logic [ADDR_W-1:0]          r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]          r_line_ptr, w_ptr_nxt;
    logic [LF_W-1:0]            r_lines_fetched, w_lf_nxt;

    logic                       w_fetch_bank;
    logic                       w_fetching;
    logic                       w_wr_en;
    logic [LF_W-1:0]            w_lf_adv;
    logic [ADDR_W-1:0]          w_ptr_adv;

    assign w_fetch_bank = ~r_disp_bank;
    assign w_fetching   = (r_state == StFetch);

    // Ending a fetch, whether complete or aborted by a line start, counts the
    // line and advances the base pointer so the next line address stays right.
    assign w_lf_adv  = r_lines_fetched + LF_W'(w_fetching);
    assign w_ptr_adv = r_line_ptr + (w_fetching ? ADDR_W'(H_DISP) : '0);

    always_comb begin
        w_state_nxt     = r_state;
        w_disp_bank_nxt = r_disp_bank;
        w_fill_nxt      = r_fill;
        w_addr_nxt      = r_addr;
        w_ptr_nxt       = r_line_ptr;
        w_lf_nxt        = r_lines_fetched;
        w_wr_en         = 1'b0;
        if (i_frame_start) begin
            w_fill_nxt[w_fetch_bank] = '0;
            w_ptr_nxt                = '0;
            w_lf_nxt                 = '0;
            w_addr_nxt               = '0;
            w_state_nxt              = StFetch;
        end else if (i_line_start) begin
            // Swap even on underrun; the displayed bank keeps its partial fill.
            w_disp_bank_nxt         = w_fetch_bank;
            w_fill_nxt[r_disp_bank] = '0;
            w_lf_nxt                = w_lf_adv;
            w_ptr_nxt               = w_ptr_adv;
            if (32'(w_lf_adv) < V_DISP) begin
                w_state_nxt = StFetch;
                w_addr_nxt  = w_ptr_adv;
            end else begin
                w_state_nxt = StIdle;
            end
        end else if (w_fetching && i_mem_ack) begin
            w_wr_en                  = 1'b1;
            w_fill_nxt[w_fetch_bank] = r_fill[w_fetch_bank] + FILL_W'(1);
            w_addr_nxt               = r_addr + ADDR_W'(1);
            if (32'(r_fill[w_fetch_bank]) == H_DISP - 1) begin
                w_state_nxt = StIdle;
                w_lf_nxt    = w_lf_adv;
                w_ptr_nxt   = w_ptr_adv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StIdle;
            r_disp_bank     <= 1'b0;
            r_fill          <= '0;
            r_addr          <= '0;
            r_line_ptr      <= '0;
            r_lines_fetched <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_disp_bank     <= w_disp_bank_nxt;
            r_fill          <= w_fill_nxt;
            r_addr          <= w_addr_nxt;
            r_line_ptr      <= w_ptr_nxt;
            r_lines_fetched <= w_lf_nxt;
        end
    end

    // Request comes straight from the state register so reset drops it at once.
    assign o_mem_req  = w_fetching;
    assign o_mem_addr = r_addr;

    // ---------------------------------------------------------------- pixels
    logic        w_x_vis, w_x_filled, w_rd_en;
    logic        r_pix_valid, r_rd_bank;
    logic [15:0] w_rdata0, w_rdata1;
    rgb888_t     w_pix;

    assign w_x_vis    = i_de && (32'(i_x) < H_DISP);
    assign w_x_filled = 32'(i_x) < 32'(r_fill[r_disp_bank]);
    assign w_rd_en    = w_x_vis && w_x_filled;

    vga_line_ram #(
        .DEPTH (H_DISP),
        .AW    (RAM_AW)
    ) u_ram0 (
        .clk     (clk),
        .i_we    (w_wr_en & r_disp_bank),
        .i_waddr (r_fill[0][RAM_AW-1:0]),
        .i_wdata (i_mem_rdata),
        .i_re    (w_rd_en & ~r_disp_bank),
        .i_raddr (RAM_AW'(i_x)),
        .o_rdata (w_rdata0)
    );

    vga_line_ram #(
        .DEPTH (H_DISP),
        .AW    (RAM_AW)
    ) u_ram1 (
        .clk     (clk),
        .i_we    (w_wr_en & ~r_disp_bank),
        .i_waddr (r_fill[1][RAM_AW-1:0]),
        .i_wdata (i_mem_rdata),
        .i_re    (w_rd_en & r_disp_bank),
        .i_raddr (RAM_AW'(i_x)),
        .o_rdata (w_rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
            r_rd_bank   <= 1'b0;
        end else begin
            r_pix_valid <= w_rd_en;
            r_rd_bank   <= r_disp_bank;
        end
    end

    assign w_pix = rgb565_to_888(rgb565_t'(r_rd_bank ? w_rdata1 : w_rdata0));

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    logic       w_abort;
    logic       r_pix_under;
    logic [7:0] r_underrun_cnt;

    assign w_abort = w_fetching && (i_frame_start || i_line_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_under    <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_pix_under <= w_x_vis && !w_x_filled;
            if (w_abort && (r_underrun_cnt != 8'hFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
            end
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;

    always_comb begin
        {o_rgb_r, o_rgb_g, o_rgb_b} = '0;
        if (r_pix_valid) begin
            {o_rgb_r, o_rgb_g, o_rgb_b} = w_pix;
        end else if (r_pix_under) begin
            {o_rgb_r, o_rgb_g, o_rgb_b} = 24'hFF00FF;
        end
    end
`else
    always_comb begin
        {o_rgb_r, o_rgb_g, o_rgb_b} = '0;
        if (r_pix_valid) begin
            {o_rgb_r, o_rgb_g, o_rgb_b} = w_pix;
        end
    end
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// ----------------------------------------------------------------------------
// tb_vga_line_fetch
// Self-checking bench for vga_line_fetch: a frame-memory responder with a
// configurable ack rate checks every acked address, and expected pixels are
// queued when a coordinate is driven and compared one cycle later.
// ----------------------------------------------------------------------------
module tb_vga_line_fetch;

`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    localparam logic [23:0] UND = 24'hFF00FF;
`else
    localparam logic [23:0] UND = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_frame_start, i_line_start, i_de;
    logic [9:0]  i_x;
    logic [7:0]  o_rgb_r, o_rgb_g, o_rgb_b;
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
    logic [7:0]  o_underrun_cnt;
`endif
    logic        o_mem_req;
    logic [19:0] o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;

    always #5 clk = ~clk;

    vga_line_fetch u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_frame_start  (i_frame_start),
        .i_line_start   (i_line_start),
        .i_de           (i_de),
        .i_x            (i_x),
        .o_rgb_r        (o_rgb_r),
        .o_rgb_g        (o_rgb_g),
        .o_rgb_b        (o_rgb_b),
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
        .o_underrun_cnt (o_underrun_cnt),
`endif
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] exp_q [$];
    logic [19:0] exp_addr = '0;
    int          n_ack = 0;
    int          ack_div = 1;
    int          div_cnt = 0;
    bit          ack_en = 1'b1;
    logic [15:0] ovr [int];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return a[15:0];
    endfunction

    function automatic logic [23:0] exp_px(input logic [15:0] w);
        logic [7:0] r, g, b;
        r = {3'b0, w[15:11]};
        g = {2'b0, w[10:5]};
        b = {3'b0, w[4:0]};
        r = (r << 3) | (r >> 2);
        g = (g << 2) | (g >> 4);
        b = (b << 3) | (b >> 2);
        return {r, g, b};
    endfunction

    // One clock: compare any queued pixel, then answer the memory request.
    task automatic step();
        logic [23:0] e;
        @(posedge clk);
        #1;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_de          = 1'b0;
        i_x           = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("pixel", {8'h0, o_rgb_r, o_rgb_g, o_rgb_b}, {8'h0, e});
        end
        i_mem_ack = 1'b0;
        if (o_mem_req && ack_en) begin
            div_cnt++;
            if (div_cnt >= ack_div) begin
                div_cnt = 0;
                check_eq("mem addr", {12'h0, o_mem_addr}, {12'h0, exp_addr});
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_word(o_mem_addr);
                exp_addr++;
                n_ack++;
            end
        end
    endtask

    task automatic drive_pix(input logic de, input int x, input logic [23:0] e);
        i_de = de;
        i_x  = 10'(x);
        exp_q.push_back(e);
        step();
    endtask

    int          xs [4] = '{5, 6, 7, 8};
    logic [23:0] cs [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284};

    initial begin
        int cyc;
        ovr[5] = 16'hF800;
        ovr[6] = 16'h07E0;
        ovr[7] = 16'h001F;
        ovr[8] = 16'h8410;
        rst_n = 1'b0;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_de          = 1'b0;
        i_x           = '0;
        i_mem_ack     = 1'b0;
        i_mem_rdata   = '0;
        #3;
        check_eq("reset rgb", {8'h0, o_rgb_r, o_rgb_g, o_rgb_b}, 32'h0);
        check_eq("reset req", {31'h0, o_mem_req}, 32'h0);
        check_eq("reset addr", {12'h0, o_mem_addr}, 32'h0);
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
        check_eq("reset ucnt", {24'h0, o_underrun_cnt}, 32'h0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_pix(1'b1, 0, UND);  // nothing fetched yet

        // Line 0 with an ack every cycle.
        i_frame_start = 1'b1;
        exp_addr = '0;
        n_ack = 0;
        cyc = 0;
        while (n_ack < 800 && cyc < 1200) begin step(); cyc++; end
        check_eq("line0 acks", n_ack, 800);
        step();
        check_eq("line0 idle", {31'h0, o_mem_req}, 32'h0);

        // Show line 0, fetch line 1 from 800.
        i_line_start = 1'b1;
        exp_addr = 20'd800;
        n_ack = 0;
        step();
        check_eq("line1 addr", {12'h0, o_mem_addr}, 32'd800);
        for (int i = 0; i < 4; i++) drive_pix(1'b1, xs[i], cs[i]);
        drive_pix(1'b0, 5, 24'h0);
        drive_pix(1'b1, 300, exp_px(16'd300));
        drive_pix(1'b1, 799, exp_px(16'd799));
        drive_pix(1'b1, 800, 24'h0);
        cyc = 0;
        while (n_ack < 800 && cyc < 2000) begin step(); cyc++; end
        check_eq("line1 acks", n_ack, 800);
        step();
        check_eq("line1 idle", {31'h0, o_mem_req}, 32'h0);

        // Line 2 at a slow ack rate, cut short after 100 words.
        ack_div = 3;
        div_cnt = 0;
        i_line_start = 1'b1;
        exp_addr = 20'd1600;
        n_ack = 0;
        cyc = 0;
        while (n_ack < 100 && cyc < 1000) begin step(); cyc++; end
        check_eq("line2 acks", n_ack, 100);
        step();
        i_line_start = 1'b1;
        exp_addr = 20'd2400;
        step();
        check_eq("underrun next addr", {12'h0, o_mem_addr}, 32'd2400);
        drive_pix(1'b1, 0, exp_px(16'd1600));
        drive_pix(1'b1, 99, exp_px(16'd1699));
        drive_pix(1'b1, 100, UND);
        drive_pix(1'b1, 799, UND);
        drive_pix(1'b1, 800, 24'h0);
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
        check_eq("ucnt one", {24'h0, o_underrun_cnt}, 32'd1);
`endif

        // A full frame of line starts, each aborting its fetch.
        ack_div = 1;
        i_frame_start = 1'b1;
        exp_addr = '0;
        for (int k = 1; k <= 600; k++) begin
            step();
            step();
            i_line_start = 1'b1;
            exp_addr = 20'(k * 800);
        end
        repeat (4) step();
        check_eq("frame end idle", {31'h0, o_mem_req}, 32'h0);
        i_line_start = 1'b1;
        repeat (3) step();
        check_eq("extra line idle", {31'h0, o_mem_req}, 32'h0);
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
        check_eq("ucnt sat", {24'h0, o_underrun_cnt}, 32'd255);
`endif
        ack_en = 1'b0;
        i_frame_start = 1'b1;
        i_line_start  = 1'b1;  // frame start must win
        step();
        check_eq("restart req", {31'h0, o_mem_req}, 32'h1);
        check_eq("restart addr", {12'h0, o_mem_addr}, 32'h0);

        // Reset in the middle of a fetch.
        ack_en = 1'b1;
        i_frame_start = 1'b1;
        exp_addr = '0;
        n_ack = 0;
        cyc = 0;
        while (n_ack < 37 && cyc < 200) begin step(); cyc++; end
        ack_en = 1'b0;
        step();
        check_eq("fill37 addr", {12'h0, o_mem_addr}, 32'd37);
        check_eq("fill37 req", {31'h0, o_mem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async rst req", {31'h0, o_mem_req}, 32'h0);
        check_eq("async rst addr", {12'h0, o_mem_addr}, 32'h0);
        check_eq("async rst rgb", {8'h0, o_rgb_r, o_rgb_g, o_rgb_b}, 32'h0);
`ifdef VGA_LINE_FETCH_UNDERRUN_EN
        check_eq("async rst ucnt", {24'h0, o_underrun_cnt}, 32'h0);
`endif
        i_mem_ack   = 1'b1;
        i_mem_rdata = 16'hFFFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("late ack ignored", {31'h0, o_mem_req}, 32'h0);
        i_mem_ack = 1'b0;
        ack_en = 1'b1;
        i_frame_start = 1'b1;
        exp_addr = '0;
        n_ack = 0;
        step();
        check_eq("post rst req", {31'h0, o_mem_req}, 32'h1);
        check_eq("post rst addr", {12'h0, o_mem_addr}, 32'h0);
        cyc = 0;
        while (n_ack < 10 && cyc < 100) begin step(); cyc++; end
        check_eq("post rst acks", n_ack, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
